rvfi_trace_buffer: RTL and testbench



---
 rtl/rvfi_trace_buffer.sv | 226 ++++++++++++++++++++++
 tb/tb_rvfi_trace_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_buffer.sv
// -----------------------------------------------------------------------------
// rvfi_trace_buffer
//
// Retire-trace capture stage sitting behind a hart's RVFI port. Every retired
// instruction seen while running is written into a small FIFO and drained to
// the trace/debug consumer over a valid/ready stream. Alongside the data path
// it tracks:
//   - order_err  : sticky, an rvfi_order value broke the +1 sequence
//   - overflow   : sticky, at least one record was lost to a full FIFO
//   - drop_count : saturating count of lost records
//   - halted     : capture stopped after a record carrying rvfi_halt
//
// Ports
//   clock, reset_n      : system clock, asynchronous active-low reset
//   rvfi_*              : retirement record from the hart (sampled on rvfi_valid)
//   clear               : synchronous clear of FIFO, flags, counter and halt state
//   out_valid/out_ready : head-of-FIFO handshake towards the consumer
//   out_*               : fields of the head record (forced to 0 when empty)
//   level               : number of stored records
//   overflow, order_err, drop_count, halted : status as described above
// -----------------------------------------------------------------------------
module rvfi_trace_buffer #(
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rvfi_valid,
  input  logic [63:0]      rvfi_order,
  input  logic [31:0]      rvfi_insn,
  input  logic             rvfi_trap,
  input  logic             rvfi_halt,
  input  logic [31:0]      rvfi_pc_rdata,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [31:0]      rvfi_rd_wdata,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_insn,
  output logic [4:0]       out_rd_addr,
  output logic [31:0]      out_rd_wdata,
  output logic             out_trap,
  output logic             out_halt,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             order_err,
  output logic [CNT_W-1:0] drop_count,
  output logic             halted
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        halt;
  } rec_t;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  rec_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;
  logic             r_order_err;
  logic [CNT_W-1:0] r_drop_count;
  logic [63:0]      r_exp_order;
  logic             r_order_armed;  // 0 until the first record after reset/clear

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic w_nonempty;
  logic w_full;
  logic w_capture;   // a retirement this cycle that we must account for
  logic w_pop;
  logic w_push;
  logic w_drop;
  rec_t w_rec;

  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == FULL_LVL);

  // clear discards everything in its cycle, including a retirement and a pop.
  assign w_capture = rvfi_valid && (r_state == S_RUN) && !clear;
  assign w_pop     = w_nonempty && out_ready && !clear;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  assign w_rec = '{pc:       rvfi_pc_rdata,
                   insn:     rvfi_insn,
                   rd_addr:  rvfi_rd_addr,
                   rd_wdata: rvfi_rd_wdata,
                   trap:     rvfi_trap,
                   halt:     rvfi_halt};

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state-holding processes use non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: a default on the first line keeps every path assigned, so no latch
    // is inferred for the next-state signal.
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN && w_capture && rvfi_halt) begin
      // Taken even when the halt record itself is dropped.
      w_state_nxt = S_HALTED;
    end
  end

  always_comb begin
    halted = (r_state == S_HALTED);
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the record array has no reset; its contents are meaningless until
  // written and the outputs are masked while empty, so a reset would only cost
  // logic on every storage bit.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status: overflow, drop counter, order check
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_order_err   <= 1'b0;
      r_exp_order   <= '0;
      r_order_armed <= 1'b0;
    end else if (clear) begin
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_order_err   <= 1'b0;
      r_exp_order   <= '0;
      r_order_armed <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
      end
      // Accepted and dropped records both advance the order tracker.
      if (w_capture) begin
        if (r_order_armed && (rvfi_order != r_exp_order)) r_order_err <= 1'b1;
        r_exp_order   <= rvfi_order + 64'd1;
        r_order_armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // out_valid derives from the async-reset level, so it drops with reset_n.
  assign out_valid  = w_nonempty;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign order_err  = r_order_err;
  assign drop_count = r_drop_count;

  always_comb begin
    out_pc       = '0;
    out_insn     = '0;
    out_rd_addr  = '0;
    out_rd_wdata = '0;
    out_trap     = 1'b0;
    out_halt     = 1'b0;
    if (w_nonempty) begin
      out_pc       = r_mem[r_rd_ptr].pc;
      out_insn     = r_mem[r_rd_ptr].insn;
      out_rd_addr  = r_mem[r_rd_ptr].rd_addr;
      out_rd_wdata = r_mem[r_rd_ptr].rd_wdata;
      out_trap     = r_mem[r_rd_ptr].trap;
      out_halt     = r_mem[r_rd_ptr].halt;
    end
  end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_rvfi_trace_buffer
//
// Directed bench for rvfi_trace_buffer (DEPTH=16, CNT_W=16). Each retirement
// carries fields derived from its order number, so the expected head record
// follows from the order value alone. Inputs are driven and outputs sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_rvfi_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset_n;
  logic             rvfi_valid;
  logic [63:0]      rvfi_order;
  logic [31:0]      rvfi_insn;
  logic             rvfi_trap;
  logic             rvfi_halt;
  logic [31:0]      rvfi_pc_rdata;
  logic [4:0]       rvfi_rd_addr;
  logic [31:0]      rvfi_rd_wdata;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_insn;
  logic [4:0]       out_rd_addr;
  logic [31:0]      out_rd_wdata;
  logic             out_trap;
  logic             out_halt;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             order_err;
  logic [CNT_W-1:0] drop_count;
  logic             halted;

  int n_checks = 0;
  int n_pass   = 0;

  rvfi_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rvfi_valid   (rvfi_valid),
    .rvfi_order   (rvfi_order),
    .rvfi_insn    (rvfi_insn),
    .rvfi_trap    (rvfi_trap),
    .rvfi_halt    (rvfi_halt),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd_addr (rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_insn     (out_insn),
    .out_rd_addr  (out_rd_addr),
    .out_rd_wdata (out_rd_wdata),
    .out_trap     (out_trap),
    .out_halt     (out_halt),
    .level        (level),
    .overflow     (overflow),
    .order_err    (order_err),
    .drop_count   (drop_count),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference field encodings, all derived from the order number.
  function automatic logic [31:0] pc_of(input int o);
    return 32'h0000_1000 + 32'(o) * 32'd4;
  endfunction
  function automatic logic [31:0] insn_of(input int o);
    return 32'hA500_0000 + 32'(o);
  endfunction
  function automatic logic [31:0] wdata_of(input int o);
    return 32'hD000_0000 ^ (32'(o) << 4);
  endfunction
  function automatic logic [4:0] rd_of(input int o);
    logic [31:0] v;
    v = 32'(o) + 32'd1;
    return v[4:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_retire(input int o, input logic halt);
    rvfi_valid    = 1'b1;
    rvfi_order    = 64'(o);
    rvfi_insn     = insn_of(o);
    rvfi_pc_rdata = pc_of(o);
    rvfi_rd_addr  = rd_of(o);
    rvfi_rd_wdata = wdata_of(o);
    rvfi_trap     = (o % 3 == 1);
    rvfi_halt     = halt;
  endtask

  task automatic idle();
    rvfi_valid = 1'b0;
    rvfi_halt  = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Compare the current head with the record built from order o.
  task automatic check_head(input string tag, input int o, input logic halt);
    check({tag, ".valid"}, 64'(out_valid),    64'd1);
    check({tag, ".pc"},    64'(out_pc),       64'(pc_of(o)));
    check({tag, ".insn"},  64'(out_insn),     64'(insn_of(o)));
    check({tag, ".rd"},    64'(out_rd_addr),  64'(rd_of(o)));
    check({tag, ".wdata"}, 64'(out_rd_wdata), 64'(wdata_of(o)));
    check({tag, ".trap"},  64'(out_trap),     64'(o % 3 == 1));
    check({tag, ".halt"},  64'(out_halt),     64'(halt));
  endtask

  initial begin
    reset_n       = 1'b0;
    clear         = 1'b0;
    out_ready     = 1'b0;
    rvfi_valid    = 1'b0;
    rvfi_order    = '0;
    rvfi_insn     = '0;
    rvfi_trap     = 1'b0;
    rvfi_halt     = 1'b0;
    rvfi_pc_rdata = '0;
    rvfi_rd_addr  = '0;
    rvfi_rd_wdata = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // ---- reset state ------------------------------------------------------
    check("rst.valid",   64'(out_valid),  64'd0);
    check("rst.level",   64'(level),      64'd0);
    check("rst.ovf",     64'(overflow),   64'd0);
    check("rst.ordErr",  64'(order_err),  64'd0);
    check("rst.drops",   64'(drop_count), 64'd0);
    check("rst.halted",  64'(halted),     64'd0);
    check("rst.pc",      64'(out_pc),     64'd0);

    // ---- three retires streamed straight through --------------------------
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_retire(i, 1'b0);
      step();
      check_head($sformatf("flow%0d", i), i, 1'b0);
      check($sformatf("flow%0d.level", i), 64'(level), 64'd1);
    end
    idle();
    step();
    check("flow.levelEnd", 64'(level),     64'd0);
    check("flow.validEnd", 64'(out_valid), 64'd0);
    check("flow.ordErr",   64'(order_err), 64'd0);

    // ---- overflow: 18 retires into a stalled FIFO, then drain -------------
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive_retire(i, 1'b0);
      step();
    end
    idle();
    check("ovf.level",  64'(level),      64'd16);
    check("ovf.drops",  64'(drop_count), 64'd2);
    check("ovf.flag",   64'(overflow),   64'd1);
    check("ovf.ordErr", 64'(order_err),  64'd0);
    step();
    check("ovf.holdPc", 64'(out_pc), 64'(pc_of(0)));
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("drain%0d", i), i, 1'b0);
      step();
    end
    check("drain.level", 64'(level),     64'd0);
    check("drain.valid", 64'(out_valid), 64'd0);

    // ---- full FIFO with same-cycle push and pop ---------------------------
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_retire(i, 1'b0);
      step();
    end
    check("pp.levelFull", 64'(level), 64'd16);
    out_ready = 1'b1;
    drive_retire(16, 1'b0);
    step();
    idle();
    check("pp.level", 64'(level),      64'd16);
    check("pp.drops", 64'(drop_count), 64'd0);
    check("pp.ovf",   64'(overflow),   64'd0);
    for (int i = 1; i <= 16; i++) begin
      check_head($sformatf("ppd%0d", i), i, 1'b0);
      step();
    end
    check("pp.levelEnd", 64'(level), 64'd0);

    // ---- order gap ---------------------------------------------------------
    do_clear();
    out_ready = 1'b1;
    drive_retire(0, 1'b0); step();
    drive_retire(1, 1'b0); step();
    check("ord.ok", 64'(order_err), 64'd0);
    drive_retire(3, 1'b0); step();
    check("ord.gap", 64'(order_err), 64'd1);
    drive_retire(4, 1'b0); step();
    idle();
    check("ord.sticky", 64'(order_err), 64'd1);
    step();

    // ---- halt at order 5 followed by two more retires ---------------------
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      drive_retire(i, i == 5);
      step();
    end
    check("hlt.halted", 64'(halted), 64'd1);
    drive_retire(6, 1'b0); step();
    drive_retire(7, 1'b0); step();
    idle();
    check("hlt.level",  64'(level),      64'd6);
    check("hlt.drops",  64'(drop_count), 64'd0);
    check("hlt.ovf",    64'(overflow),   64'd0);
    check("hlt.halted2",64'(halted),     64'd1);
    out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      check_head($sformatf("hltd%0d", i), i, i == 5);
      step();
    end
    check("hlt.levelEnd", 64'(level), 64'd0);

    // ---- clear while full, overflowed, order-errored and halted -----------
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_retire(i, 1'b0);
      step();
    end
    drive_retire(20, 1'b1);  // gap and halt, dropped because full
    step();
    idle();
    check("clr.preLevel",  64'(level),      64'd16);
    check("clr.preDrops",  64'(drop_count), 64'd2);
    check("clr.preOvf",    64'(overflow),   64'd1);
    check("clr.preOrdErr", 64'(order_err),  64'd1);
    check("clr.preHalted", 64'(halted),     64'd1);
    // clear with a competing retirement and pop request in the same cycle
    out_ready = 1'b1;
    drive_retire(21, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle();
    out_ready = 1'b0;
    check("clr.level",  64'(level),      64'd0);
    check("clr.valid",  64'(out_valid),  64'd0);
    check("clr.ovf",    64'(overflow),   64'd0);
    check("clr.ordErr", 64'(order_err),  64'd0);
    check("clr.drops",  64'(drop_count), 64'd0);
    check("clr.halted", 64'(halted),     64'd0);
    drive_retire(99, 1'b0);
    step();
    idle();
    check("clr.firstOrd", 64'(order_err), 64'd0);
    check("clr.level1",   64'(level),     64'd1);
    check_head("clr.head", 99, 1'b0);

    // ---- asynchronous reset with a record stored --------------------------
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.level", 64'(level),     64'd0);
    step();
    reset_n = 1'b1;
    step();
    check("arst.after", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
